// File: rtl/counter_disp_sel.sv
// Multi-channel counter display selector: scans DIGITS BCD digits of the active channel
// and switches channels only on scan-frame boundaries so a frame never mixes two channels.
module counter_disp_sel #(
    parameter  int CH       = 4,
    parameter  int DIGITS   = 4,
    parameter  int LIGHT_W  = 16,
    parameter  int SCAN_DIV = 1024,
    localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel_next,
    input  logic                     sel_load,
    input  logic [CH_W-1:0]          sel_val,
    input  logic [CH*DIGITS*4-1:0]   bcd_in,
    input  logic [CH*LIGHT_W-1:0]    light_in,
    input  logic [CH-1:0]            stop_in,
    output logic [CH_W-1:0]          active_ch,
    output logic                     pending,
    output logic [3:0]               digit_out,
    output logic [DIGITS-1:0]        digit_en,
    output logic [LIGHT_W-1:0]       light_out,
    output logic                     stop_out,
    output logic                     frame_tick
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(CH - 1);

    logic [DIV_W-1:0]   r_div;
    logic [IDX_W-1:0]   r_idx;
    logic [CH_W-1:0]    r_req;
    logic [CH_W-1:0]    r_active;
    logic [3:0]         r_digit;
    logic [DIGITS-1:0]  r_en;
    logic [LIGHT_W-1:0] r_light;
    logic               r_stop;
    logic               r_tick;

    logic               w_div_wrap;
    logic               w_frame_end;
    logic [3:0]         w_bcd   [CH][DIGITS];
    logic [LIGHT_W-1:0] w_light [CH];

    for (genvar c = 0; c < CH; c++) begin : g_ch
        for (genvar d = 0; d < DIGITS; d++) begin : g_dig
            assign w_bcd[c][d] = bcd_in[(c*DIGITS + d)*4 +: 4];
        end
        assign w_light[c] = light_in[c*LIGHT_W +: LIGHT_W];
    end

    assign w_div_wrap  = (r_div == DIV_MAX);
    assign w_frame_end = w_div_wrap && (r_idx == IDX_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (w_div_wrap) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // An out-of-range load swallows the whole request, including a simultaneous sel_next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= '0;
        end else if (sel_load) begin
            if (sel_val <= CH_MAX) begin
                r_req <= sel_val;
            end
        end else if (sel_next) begin
            r_req <= (r_req == CH_MAX) ? '0 : r_req + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= '0;
        end else if (w_frame_end) begin
            r_active <= r_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit <= '0;
            r_en    <= '1;
            r_light <= '0;
            r_stop  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_digit <= w_bcd[r_active][r_idx];
            r_en    <= ~(DIGITS'(1) << r_idx);
            r_light <= w_light[r_active];
            r_stop  <= stop_in[r_active];
            r_tick  <= w_frame_end;
        end
    end

    assign active_ch  = r_active;
    assign pending    = (r_req != r_active);
    assign digit_out  = r_digit;
    assign digit_en   = r_en;
    assign light_out  = r_light;
    assign stop_out   = r_stop;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_counter_disp_sel.sv
// Randomized self-checking bench for counter_disp_sel against a frame-position reference model,
// plus a small CH=3 instance for out-of-range loads and non-power-of-two wrap.
module tb_counter_disp_sel;

    localparam int CH       = 4;
    localparam int DIGITS   = 4;
    localparam int LIGHT_W  = 16;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic                   clk;
    logic                   rst;
    logic                   sel_next, sel_load;
    logic [1:0]             sel_val;
    logic [CH*DIGITS*4-1:0] bcd_in;
    logic [CH*LIGHT_W-1:0]  light_in;
    logic [CH-1:0]          stop_in;
    logic [1:0]             active_ch;
    logic                   pending;
    logic [3:0]             digit_out;
    logic [DIGITS-1:0]      digit_en;
    logic [LIGHT_W-1:0]     light_out;
    logic                   stop_out;
    logic                   frame_tick;

    logic        s3_next, s3_load;
    logic [1:0]  s3_val;
    logic [23:0] bcd3;
    logic [11:0] light3;
    logic [2:0]  stop3;
    logic [1:0]  act3;
    logic        pend3;
    logic [3:0]  digit3;
    logic [1:0]  en3;
    logic [3:0]  light3_o;
    logic        stop3_o;
    logic        tick3;

    int n_checks = 0;
    int n_fail   = 0;

    int               m_k, m_req, m_act;
    logic [3:0]       e_digit;
    logic [DIGITS-1:0] e_en;
    logic [LIGHT_W-1:0] e_light;
    logic             e_stop, e_tick;
    logic             fix_ch0 = 1'b0;

    counter_disp_sel #(.CH(CH), .DIGITS(DIGITS), .LIGHT_W(LIGHT_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .sel_next(sel_next), .sel_load(sel_load), .sel_val(sel_val),
        .bcd_in(bcd_in), .light_in(light_in), .stop_in(stop_in),
        .active_ch(active_ch), .pending(pending), .digit_out(digit_out), .digit_en(digit_en),
        .light_out(light_out), .stop_out(stop_out), .frame_tick(frame_tick)
    );

    counter_disp_sel #(.CH(3), .DIGITS(2), .LIGHT_W(4), .SCAN_DIV(2)) dut3 (
        .clk(clk), .rst(rst), .sel_next(s3_next), .sel_load(s3_load), .sel_val(s3_val),
        .bcd_in(bcd3), .light_in(light3), .stop_in(stop3),
        .active_ch(act3), .pending(pend3), .digit_out(digit3), .digit_en(en3),
        .light_out(light3_o), .stop_out(stop3_o), .frame_tick(tick3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k     = 0;
        m_req   = 0;
        m_act   = 0;
        e_digit = '0;
        e_en    = '1;
        e_light = '0;
        e_stop  = 1'b0;
        e_tick  = 1'b0;
    endtask

    // Expected outputs come from the scan position within the frame, taken before this edge.
    task automatic model_edge();
        int pos, idx;
        if (rst) begin
            model_reset();
            return;
        end
        pos     = m_k % FRAME;
        idx     = pos / SCAN_DIV;
        e_digit = bcd_in[(m_act*DIGITS + idx)*4 +: 4];
        e_en    = '1;
        e_en[idx] = 1'b0;
        e_light = light_in[m_act*LIGHT_W +: LIGHT_W];
        e_stop  = stop_in[m_act];
        e_tick  = (pos == FRAME - 1);
        if (e_tick) m_act = m_req;
        if (sel_load) begin
            if (int'(sel_val) < CH) m_req = int'(sel_val);
        end else if (sel_next) begin
            m_req = (m_req + 1) % CH;
        end
        m_k++;
    endtask

    task automatic check_all();
        check("digit_out", digit_out, e_digit);
        check("digit_en", digit_en, e_en);
        check("light_out", light_out, e_light);
        check("stop_out", stop_out, e_stop);
        check("frame_tick", frame_tick, e_tick);
        check("active_ch", active_ch, m_act);
        check("pending", pending, (m_req != m_act));
    endtask

    task automatic cycle(input logic nx, input logic ld, input logic [1:0] v);
        sel_next = nx;
        sel_load = ld;
        sel_val  = v;
        bcd_in   = {$urandom, $urandom};
        if (fix_ch0) bcd_in[15:0] = 16'h4321;
        light_in = {$urandom, $urandom};
        stop_in  = 4'($urandom);
        bcd3     = 24'($urandom);
        light3   = 12'($urandom);
        stop3    = 3'($urandom);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        sel_next = 1'b0;
        sel_load = 1'b0;
        s3_next  = 1'b0;
        s3_load  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        int n_tick;
        rst = 1'b1;
        sel_next = 1'b0; sel_load = 1'b0; sel_val = '0;
        s3_next = 1'b0; s3_load = 1'b0; s3_val = '0;
        bcd_in = '0; light_in = '0; stop_in = '0;
        bcd3 = '0; light3 = '0; stop3 = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        check("rst_en3", en3, 2'b11);
        rst = 1'b0;

        // Scan order with ch0 fixed at 4321
        fix_ch0 = 1'b1;
        n_tick = 0;
        cycle(1'b0, 1'b0, 2'd0);
        check("scan_first_digit", digit_out, 4'd1);
        check("scan_first_en", digit_en, 4'b1110);
        for (int i = 1; i < FRAME; i++) begin
            cycle(1'b0, 1'b0, 2'd0);
            if (frame_tick) n_tick++;
        end
        check("tick_per_frame", n_tick, 1);
        fix_ch0 = 1'b0;

        // Deferred switch requested at frame cycle 5
        while ((m_k % FRAME) != 5) idle(1);
        cycle(1'b1, 1'b0, 2'd0);
        check("defer_pending", pending, 1'b1);
        check("defer_active", active_ch, 2'd0);
        while ((m_k % FRAME) != 0) idle(1);
        check("defer_switched", active_ch, 2'd1);
        idle(1);
        check("defer_first_en", digit_en, 4'b1110);

        // Wrap from 3 and load-over-next priority
        cycle(1'b0, 1'b1, 2'd3);
        cycle(1'b1, 1'b0, 2'd0);
        cycle(1'b1, 1'b1, 2'd2);
        idle(FRAME + 1);
        check("priority_active", active_ch, 2'd2);

        // Request landing on the frame_end edge waits a full frame
        while ((m_k % FRAME) != FRAME - 1) idle(1);
        cycle(1'b1, 1'b0, 2'd0);
        check("coinc_active", active_ch, 2'd2);
        check("coinc_pending", pending, 1'b1);
        idle(FRAME - 1);
        check("coinc_still_pending", pending, 1'b1);
        idle(1);
        check("coinc_switched", active_ch, 2'd3);

        // Asynchronous reset while a request is pending at idx 2
        while ((m_k % FRAME) != 0) idle(1);
        cycle(1'b1, 1'b0, 2'd0);
        while (((m_k % FRAME) / SCAN_DIV) != 2) idle(1);
        check("pre_rst_pending", pending, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst_en", digit_en, 4'b1111);
        check("rst_active", active_ch, 2'd0);
        check("rst_pending", pending, 1'b0);
        idle(3);
        rst = 1'b0;
        idle(1);
        check("post_rst_en", digit_en, 4'b1110);

        // Random request traffic
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), 2'($urandom));
        end

        // CH=3 instance: wrap at 2 and out-of-range loads
        s3_next = 1'b1; idle(1);
        check("ch3_pending", pend3, 1'b1);
        idle(5);
        check("ch3_active1", act3, 2'd1);
        s3_load = 1'b1; s3_next = 1'b1; s3_val = 2'd3; idle(1);
        check("ch3_bad_load_pending", pend3, 1'b0);
        idle(5);
        check("ch3_bad_load_active", act3, 2'd1);
        s3_next = 1'b1; idle(1);
        s3_next = 1'b1; idle(1);
        check("ch3_wrap_pending", pend3, 1'b1);
        idle(5);
        check("ch3_wrap_active", act3, 2'd0);
        s3_load = 1'b1; s3_val = 2'd2; idle(6);
        check("ch3_load_active", act3, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
